// File: rtl/kv_ledger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kv_ledger_pkg
//  Description : Shared op codes, status codes, FSM state encoding and the
//                hash helper for the two-way hashed key/value ledger.
//  Config      : none (the engine uses KV_UNDERFLOW_GUARD_EN)
//  Revision    : 1.0  initial release
// ============================================================================
package kv_ledger_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH   = 2'd0,
        OP_INSERT   = 2'd1,
        OP_TRANSACT = 2'd2,
        OP_DELETE   = 2'd3
    } kv_op_t;

    typedef enum logic [2:0] {
        KV_OK        = 3'd0,
        KV_NOT_FOUND = 3'd1,
        KV_FULL      = 3'd2,
        KV_UNDERFLOW = 3'd3,
        KV_OVERFLOW  = 3'd4
    } kv_status_t;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_EVAL  = 3'd3,
        S_RESP  = 3'd4
    } kv_state_t;

    // One bit of the second-table hash: low-field bit XOR high-field bit,
    // inverted. Applied bitwise so it stays width-agnostic.
    function automatic logic kv_h2_bit(input logic lo, input logic hi);
        return ~(lo ^ hi);
    endfunction

endpackage : kv_ledger_pkg
`default_nettype wire

// File: rtl/kv_ledger_bank.sv
`default_nettype none
// ============================================================================
//  Module      : kv_ledger_bank
//  Description : DEPTH x {valid,key,value} single-port table with a 1-cycle
//                registered read, a write port and a valid-clear port used by
//                the post-reset sweep. Storage itself is never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module kv_ledger_bank
    import kv_ledger_pkg::*;
#(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int ADDR_BITS = 9
) (
    input  logic                 i_clock,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_rd_en,
    input  logic                 i_wr_en,
    input  logic                 i_wr_valid,
    input  logic [KEY_W-1:0]     i_wr_key,
    input  logic [VAL_W-1:0]     i_wr_val,
    input  logic                 i_clr_en,
    output logic                 o_rd_valid,
    output logic [KEY_W-1:0]     o_rd_key,
    output logic [VAL_W-1:0]     o_rd_val
);

    localparam int C_DEPTH = 2 ** ADDR_BITS;

    logic             r_valid   [C_DEPTH];
    logic [KEY_W-1:0] r_key_mem [C_DEPTH];
    logic [VAL_W-1:0] r_val_mem [C_DEPTH];

    // Valid bits: the clear sweep wins over a functional write.
    always_ff @(posedge i_clock) begin
        if (i_clr_en) begin
            r_valid[i_addr] <= 1'b0;
        end else if (i_wr_en) begin
            r_valid[i_addr] <= i_wr_valid;
        end
    end

    // Key/value payload write.
    always_ff @(posedge i_clock) begin
        if (i_wr_en && !i_clr_en) begin
            r_key_mem[i_addr] <= i_wr_key;
            r_val_mem[i_addr] <= i_wr_val;
        end
    end

    // Registered read; output holds between reads so EVAL sees stable data.
    always_ff @(posedge i_clock) begin
        if (i_rd_en) begin
            o_rd_valid <= r_valid[i_addr];
            o_rd_key   <= r_key_mem[i_addr];
            o_rd_val   <= r_val_mem[i_addr];
        end
    end

endmodule : kv_ledger_bank
`default_nettype wire

// File: rtl/kv_ledger_engine.sv
`default_nettype none
// ============================================================================
//  Module      : kv_ledger_engine
//  Description : Two-way hashed key/value ledger (SEARCH / INSERT / TRANSACT /
//                DELETE) with valid/ready request and response channels, one
//                op in flight and a valid-bit sweep after every reset.
//  Config      : KV_UNDERFLOW_GUARD_EN - reject debits below zero and credits
//                that carry out, instead of wrapping.
//  Note        : KEY_W must be >= 2*ADDR_BITS (second hash uses two fields).
//  Revision    : 1.0  initial release
// ============================================================================
module kv_ledger_engine
    import kv_ledger_pkg::*;
#(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [KEY_W-1:0]     req_key,
    input  logic [VAL_W-1:0]     req_value,
    input  logic                 req_kind,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           resp_status,
    output logic [VAL_W-1:0]     resp_value,
    output logic [ADDR_BITS+1:0] occupancy
);

`ifdef KV_UNDERFLOW_GUARD_EN
    localparam int C_ARITH_W = VAL_W + 1;   // extra bit carries carry/borrow
`else
    localparam int C_ARITH_W = VAL_W;       // plain modulo arithmetic
`endif

    kv_state_t              r_state;
    kv_state_t              w_state_nxt;
    logic [ADDR_BITS-1:0]   r_idx;
    kv_op_t                 r_op;
    logic [KEY_W-1:0]       r_key;
    logic [VAL_W-1:0]       r_value;
    logic                   r_kind;
    logic [2:0]             r_resp_status;
    logic [VAL_W-1:0]       r_resp_value;
    logic [ADDR_BITS+1:0]   r_occ;

    logic                   w_accept;
    logic                   w_rd_en;
    logic                   w_clr_en;
    logic                   w_in_eval;
    logic [ADDR_BITS-1:0]   w_h1;
    logic [ADDR_BITS-1:0]   w_h2;
    logic [ADDR_BITS-1:0]   w_addr1;
    logic [ADDR_BITS-1:0]   w_addr2;

    logic                   w_rd_valid1, w_rd_valid2;
    logic [KEY_W-1:0]       w_rd_key1,   w_rd_key2;
    logic [VAL_W-1:0]       w_rd_val1,   w_rd_val2;
    logic                   w_hit1, w_hit2;
    logic [VAL_W-1:0]       w_old;
    logic [C_ARITH_W-1:0]   w_sum, w_diff, w_arith;
    logic [VAL_W-1:0]       w_new;

    logic                   w_wr1, w_wr2, w_wr_valid;
    logic [VAL_W-1:0]       w_wr_val;
    kv_status_t             w_status;
    logic [VAL_W-1:0]       w_rvalue;
    logic                   w_occ_inc, w_occ_dec;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_in_eval   = (r_state == S_EVAL);
    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_status = r_resp_status;
    assign resp_value  = r_resp_value;
    assign occupancy   = r_occ;

    // Hash indices of the captured key for table 1 and table 2.
    assign w_h1 = r_key[ADDR_BITS-1:0];
    always_comb begin
        w_h2 = '0;
        for (int i = 0; i < ADDR_BITS; i++) begin
            w_h2[i] = kv_h2_bit(r_key[i], r_key[i + ADDR_BITS]);
        end
    end

    // State register; reset drops any in-flight op and restarts the sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and table sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_idx == {ADDR_BITS{1'b1}}) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd_en     = 1'b1;
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    assign w_addr1 = (r_state == S_CLEAR) ? r_idx : w_h1;
    assign w_addr2 = (r_state == S_CLEAR) ? r_idx : w_h2;

    // Sweep index, counting only while clearing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_idx <= r_idx + ADDR_BITS'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // Request fields are captured once, at the accepting edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= OP_SEARCH;
            r_key   <= '0;
            r_value <= '0;
            r_kind  <= 1'b0;
        end else if (w_accept) begin
            r_op    <= kv_op_t'(req_op);
            r_key   <= req_key;
            r_value <= req_value;
            r_kind  <= req_kind;
        end
    end

    // Hit detection: table 1 has priority, so table 2 only counts alone.
    assign w_hit1  = w_rd_valid1 && (w_rd_key1 == r_key);
    assign w_hit2  = !w_hit1 && w_rd_valid2 && (w_rd_key2 == r_key);
    assign w_old   = w_hit1 ? w_rd_val1 : w_rd_val2;
    assign w_sum   = C_ARITH_W'(w_old) + C_ARITH_W'(r_value);
    assign w_diff  = C_ARITH_W'(w_old) - C_ARITH_W'(r_value);
    assign w_arith = r_kind ? w_sum : w_diff;
    assign w_new   = w_arith[VAL_W-1:0];

    // Op evaluation: decides writes, status and returned value in EVAL.
    always_comb begin
        w_wr1      = 1'b0;
        w_wr2      = 1'b0;
        w_wr_valid = 1'b1;
        w_wr_val   = r_value;
        w_status   = KV_NOT_FOUND;
        w_rvalue   = '0;
        w_occ_inc  = 1'b0;
        w_occ_dec  = 1'b0;
        case (r_op)
            OP_SEARCH: begin
                if (w_hit1 || w_hit2) begin
                    w_status = KV_OK;
                    w_rvalue = w_old;
                end
            end
            OP_INSERT: begin
                if (w_hit1) begin
                    w_wr1 = 1'b1;
                end else if (w_hit2) begin
                    w_wr2 = 1'b1;
                end else if (!w_rd_valid1) begin
                    w_wr1     = 1'b1;
                    w_occ_inc = 1'b1;
                end else if (!w_rd_valid2) begin
                    w_wr2     = 1'b1;
                    w_occ_inc = 1'b1;
                end
                if (w_wr1 || w_wr2) begin
                    w_status = KV_OK;
                    w_rvalue = r_value;
                end else begin
                    w_status = KV_FULL;
                end
            end
            OP_DELETE: begin
                if (w_hit1 || w_hit2) begin
                    w_wr1      = w_hit1;
                    w_wr2      = w_hit2;
                    w_wr_valid = 1'b0;
                    w_status   = KV_OK;
                    w_rvalue   = w_old;
                    w_occ_dec  = 1'b1;
                end
            end
            OP_TRANSACT: begin
                if (w_hit1 || w_hit2) begin
`ifdef KV_UNDERFLOW_GUARD_EN
                    if (w_arith[VAL_W]) begin
                        w_status = r_kind ? KV_OVERFLOW : KV_UNDERFLOW;
                        w_rvalue = w_old;
                    end else begin
                        w_wr1    = w_hit1;
                        w_wr2    = w_hit2;
                        w_wr_val = w_new;
                        w_status = KV_OK;
                        w_rvalue = w_new;
                    end
`else
                    w_wr1    = w_hit1;
                    w_wr2    = w_hit2;
                    w_wr_val = w_new;
                    w_status = KV_OK;
                    w_rvalue = w_new;
`endif
                end
            end
            default: begin
                w_status = KV_NOT_FOUND;
            end
        endcase
    end

    // Response registers and occupancy, updated only as EVAL completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_status <= 3'd0;
            r_resp_value  <= '0;
            r_occ         <= '0;
        end else if (w_in_eval) begin
            r_resp_status <= w_status;
            r_resp_value  <= w_rvalue;
            if (w_occ_inc) begin
                r_occ <= r_occ + (ADDR_BITS+2)'(1);
            end else if (w_occ_dec) begin
                r_occ <= r_occ - (ADDR_BITS+2)'(1);
            end
        end
    end

    kv_ledger_bank #(
        .KEY_W     (KEY_W),
        .VAL_W     (VAL_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_bank1 (
        .i_clock    (clock),
        .i_addr     (w_addr1),
        .i_rd_en    (w_rd_en),
        .i_wr_en    (w_wr1 && w_in_eval),
        .i_wr_valid (w_wr_valid),
        .i_wr_key   (r_key),
        .i_wr_val   (w_wr_val),
        .i_clr_en   (w_clr_en),
        .o_rd_valid (w_rd_valid1),
        .o_rd_key   (w_rd_key1),
        .o_rd_val   (w_rd_val1)
    );

    kv_ledger_bank #(
        .KEY_W     (KEY_W),
        .VAL_W     (VAL_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_bank2 (
        .i_clock    (clock),
        .i_addr     (w_addr2),
        .i_rd_en    (w_rd_en),
        .i_wr_en    (w_wr2 && w_in_eval),
        .i_wr_valid (w_wr_valid),
        .i_wr_key   (r_key),
        .i_wr_val   (w_wr_val),
        .i_clr_en   (w_clr_en),
        .o_rd_valid (w_rd_valid2),
        .o_rd_key   (w_rd_key2),
        .o_rd_val   (w_rd_val2)
    );

endmodule : kv_ledger_engine
`default_nettype wire

// File: tb/tb_kv_ledger_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kv_ledger_engine
//  Description : Self-checking bench for kv_ledger_engine (KEY_W=32, VAL_W=32,
//                ADDR_BITS=4). Directed scenarios plus random ops compared
//                against a behavioural two-way ledger model.
//  Config      : honours KV_UNDERFLOW_GUARD_EN in the reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kv_ledger_engine;

    localparam int KW    = 32;
    localparam int VW    = 32;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int PER   = 10;

    logic          clock;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [KW-1:0] req_key;
    logic [VW-1:0] req_value;
    logic          req_kind;
    logic          resp_valid;
    logic          resp_ready;
    logic [2:0]    resp_status;
    logic [VW-1:0] resp_value;
    logic [AB+1:0] occupancy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: table w holds entries at index slot(w,key).
    bit          m_v   [2][DEPTH];
    logic [31:0] m_k   [2][DEPTH];
    logic [31:0] m_val [2][DEPTH];

    kv_ledger_engine #(.KEY_W(KW), .VAL_W(VW), .ADDR_BITS(AB)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_key     (req_key),
        .req_value   (req_value),
        .req_kind    (req_kind),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_value  (resp_value),
        .occupancy   (occupancy)
    );

    initial clock = 1'b0;
    always #(PER/2) clock = ~clock;

    initial begin
        #(PER * 50000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DEPTH; i++) m_v[w][i] = 1'b0;
    endfunction

    function automatic int model_occ();
        int n = 0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DEPTH; i++) n += int'(m_v[w][i]);
        return n;
    endfunction

    function automatic void model_apply(input logic [1:0] op, input logic [31:0] key,
                                        input logic [31:0] val, input logic kind,
                                        output logic [2:0] st, output logic [31:0] rv);
        int     slot [2];
        int     t;
        int     f;
        longint bal, nv;
        longint c_max = 64'h0000_0000_FFFF_FFFF;
        slot[0] = int'(key[3:0]);
        slot[1] = int'(key[3:0] ^ key[7:4] ^ 4'hF);
        t = -1;
        for (int w = 0; w < 2; w++)
            if (t < 0 && m_v[w][slot[w]] && m_k[w][slot[w]] == key) t = w;
        st = 3'd1;
        rv = 32'd0;
        case (op)
            2'd0: if (t >= 0) begin st = 3'd0; rv = m_val[t][slot[t]]; end
            2'd1: begin
                f = t;
                for (int w = 0; w < 2; w++)
                    if (f < 0 && !m_v[w][slot[w]]) f = w;
                if (f >= 0) begin
                    m_v[f][slot[f]] = 1'b1; m_k[f][slot[f]] = key; m_val[f][slot[f]] = val;
                    st = 3'd0; rv = val;
                end else begin
                    st = 3'd2;
                end
            end
            2'd3: if (t >= 0) begin
                rv = m_val[t][slot[t]]; m_v[t][slot[t]] = 1'b0; st = 3'd0;
            end
            default: if (t >= 0) begin
                bal = longint'({32'd0, m_val[t][slot[t]]});
                nv  = kind ? bal + longint'({32'd0, val}) : bal - longint'({32'd0, val});
`ifdef KV_UNDERFLOW_GUARD_EN
                if (nv < 0) begin
                    st = 3'd3; rv = bal[31:0];
                end else if (nv > c_max) begin
                    st = 3'd4; rv = bal[31:0];
                end else begin
                    st = 3'd0; rv = nv[31:0]; m_val[t][slot[t]] = rv;
                end
`else
                st = 3'd0; rv = nv[31:0]; m_val[t][slot[t]] = rv;
`endif
            end
        endcase
    endfunction

    // Issue one op, check latency, response fields and occupancy.
    // hold > 0 keeps resp_ready low for that many cycles first.
    task automatic run_op(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                          input logic kind, input int hold, input string tag);
        logic [2:0]  est;
        logic [31:0] ev;
        int          w;
        int          lat;
        @(negedge clock);
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clock); w++; end
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_key    = key;
        req_value  = val;
        req_kind   = kind;
        resp_ready = (hold == 0);
        model_apply(op, key, val, kind, est, ev);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_key   = $urandom;
        req_value = $urandom;
        req_kind  = 1'($urandom);
        chk({tag, " busy"}, 64'(req_ready), 64'd0);
        // lat = index of the edge (after accept) at which resp_valid is first sampled high
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        chk({tag, " latency"}, 64'(lat), 64'd3);
        chk({tag, " status"}, 64'(resp_status), 64'(est));
        chk({tag, " value"}, 64'(resp_value), 64'(ev));
        chk({tag, " occupancy"}, 64'(occupancy), 64'(model_occ()));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            chk({tag, " hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, " hold_status"}, 64'(resp_status), 64'(est));
            chk({tag, " hold_value"}, 64'(resp_value), 64'(ev));
            chk({tag, " hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, " resp_taken"}, 64'(resp_valid), 64'd0);
    endtask

    // Count clocks from reset release until req_ready, watching for stray responses.
    task automatic release_and_sweep(input string tag);
        int cnt;
        bit stray;
        @(negedge clock);
        reset_n = 1'b1;
        cnt     = 0;
        stray   = 1'b0;
        while (!req_ready && cnt < 100) begin
            @(posedge clock);
            #1;
            cnt++;
            if (resp_valid) stray = 1'b1;
        end
        chk({tag, " clear_cycles"}, 64'(cnt), 64'd16);
        chk({tag, " no_response"}, 64'(stray), 64'd0);
        chk({tag, " occupancy"}, 64'(occupancy), 64'd0);
    endtask

    logic [2:0]  q_st  [$];
    logic [31:0] q_val [$];
    int          q_occ [$];
    int          n_resp;

    task automatic pop_resp();
        if (q_st.size() == 0) begin
            chk("b2b unexpected_response", 64'd1, 64'd0);
        end else begin
            chk("b2b status", 64'(resp_status), 64'(q_st.pop_front()));
            chk("b2b value", 64'(resp_value), 64'(q_val.pop_front()));
            chk("b2b occupancy", 64'(occupancy), 64'(q_occ.pop_front()));
            n_resp++;
        end
    endtask

    function automatic logic [31:0] rand_key();
        logic [31:0] r;
        r = $urandom;
        r[7:0] = {2'b00, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 4'h2 : 4'h9};
        return r;
    endfunction

    initial begin
        logic [2:0]  est;
        logic [31:0] ev;
        logic [31:0] k;
        logic [31:0] v;
        logic [1:0]  op;
        int          cnt;
        time         t_prev;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_key    = '0;
        req_value  = '0;
        req_kind   = 1'b0;
        resp_ready = 1'b1;
        n_resp     = 0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_status", 64'(resp_status), 64'd0);
        chk("reset resp_value", 64'(resp_value), 64'd0);
        chk("reset occupancy", 64'(occupancy), 64'd0);
        release_and_sweep("por");

        // Shared-slot collision: both candidate slots taken -> FULL
        run_op(2'd1, 32'h009, 32'h11, 1'b0, 0, "ins_009");
        run_op(2'd1, 32'h109, 32'h22, 1'b0, 0, "ins_109");
        run_op(2'd1, 32'h209, 32'h33, 1'b0, 0, "ins_209_full");
        run_op(2'd3, 32'h009, 32'h0,  1'b0, 0, "del_009");
        run_op(2'd1, 32'h209, 32'h44, 1'b0, 0, "ins_209_ok");

        // Reset pulse while an op is in READ: op dropped, table re-swept
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'd1; req_key = 32'h55; req_value = 32'd1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("midop in_read", 64'(resp_valid), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("midop async req_ready", 64'(req_ready), 64'd0);
        chk("midop async occupancy", 64'(occupancy), 64'd0);
        chk("midop async status", 64'(resp_status), 64'd0);
        model_clear();
        release_and_sweep("midop");
        run_op(2'd0, 32'h109, 32'h0, 1'b0, 0, "post_reset_srch_109");
        run_op(2'd0, 32'h55,  32'h0, 1'b0, 0, "post_reset_srch_55");

        // Basic ledger flow
        run_op(2'd1, 32'd249, 32'd1000, 1'b0, 0, "ins_249");
        run_op(2'd0, 32'd249, 32'd0, 1'b0, 0, "srch_249");
        run_op(2'd0, 32'd892, 32'd0, 1'b0, 0, "srch_892");
        run_op(2'd2, 32'd249, 32'd100, 1'b1, 0, "credit_100");
        run_op(2'd2, 32'd249, 32'd2000, 1'b0, 0, "debit_2000");
        run_op(2'd1, 32'd7, 32'hFFFF_FFF0, 1'b0, 0, "ins_7");
        run_op(2'd2, 32'd7, 32'h20, 1'b1, 0, "credit_carry");
        run_op(2'd2, 32'd1234, 32'h20, 1'b1, 0, "transact_miss");
        run_op(2'd3, 32'd1234, 32'h0, 1'b0, 0, "del_miss");
        // Overwrite in place with a stalled consumer
        run_op(2'd1, 32'd249, 32'd5, 1'b0, 10, "reins_249_hold");
        run_op(2'd0, 32'd249, 32'd0, 1'b0, 0, "srch_249_new");

        // Random ops against the model
        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 3));
            k  = rand_key();
            v  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5000));
            run_op(op, k, v, 1'($urandom), 0, "rand");
        end

        // Back-to-back requests, resp_ready tied high: one accept per 4 clocks
        resp_ready = 1'b1;
        t_prev     = 0;
        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            k  = rand_key();
            v  = 32'($urandom_range(0, 3000));
            req_op = op; req_key = k; req_value = v; req_kind = 1'($urandom);
            model_apply(op, k, v, req_kind, est, ev);
            q_st.push_back(est);
            q_val.push_back(ev);
            q_occ.push_back(model_occ());
            req_valid = 1'b1;
            cnt = 0;
            while (!req_ready && cnt < 20) begin
                if (resp_valid) pop_resp();
                @(negedge clock);
                cnt++;
            end
            chk("b2b ready", 64'(req_ready), 64'd1);
            @(posedge clock);
            if (i > 0) chk("b2b accept_gap", 64'(($time - t_prev) / PER), 64'd4);
            t_prev = $time;
            @(negedge clock);
        end
        req_valid = 1'b0;
        cnt = 0;
        while (q_st.size() > 0 && cnt < 20) begin
            if (resp_valid) pop_resp();
            @(negedge clock);
            cnt++;
        end
        chk("b2b responses", 64'(n_resp), 64'd12);
        chk("b2b leftover", 64'(q_st.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_kv_ledger_engine
`default_nettype wire
